exp_frame_scheduler: RTL
========================

Name: exp_frame_scheduler

Overview:
Frame-level sequencer between the host configuration wires and the exposure engine / readout engine pair.
- Owns the exposure handshake: drives the exposure engine's re_busy input and consumes its trigger_o.
- Launches readout and applies FIFO back-pressure.
- Supports single, N-frame and continuous capture.
- Atomically loads shadowed timing and sub-frame settings so a frame never runs with a half-updated set.

Parameters:
NUM_T, 13, number of 32-bit timing words (order: T_stdby, T_reset, Tgl_res, Texp_ctrl, T1..T9).
OVERLAP, 0, 1 = next exposure may launch while readout of the previous frame is still busy.
WDOG_CYCLES, 32'd200_000_000, maximum CLKM cycles allowed in EXPOSE or RO_ACK before error.

Ports:
CLKM  in  1  sole clock.
rst_n  in  1  asynchronous, active-low reset.
cfg_mode  in  2  0 = stop, 1 = single, 2 = N frames, 3 = continuous.
cfg_num_frames  in  32  frame count for mode 2.
cfg_start  in  1  one-cycle start pulse.
cfg_stop  in  1  one-cycle stop pulse.
cfg_update  in  1  one-cycle request to load the shadow registers.
cfg_num_sub_in  in  32  staged NUM_SUB.
cfg_timing_in  in  NUM_T*32  staged timing words; word 0 in the LSBs.
cfg_num_sub_act  out  32  active NUM_SUB fed to the exposure engine.
cfg_timing_act  out  NUM_T*32  active timing words fed to the exposure engine.
exp_re_busy  out  1  to the exposure engine's re_busy.
exp_trigger  in  1  from the exposure engine's trigger_o.
ro_start  out  1  one-cycle readout launch pulse.
ro_busy  in  1  readout engine busy.
fifo_prog_full  in  1  output FIFO programmable-full flag.
busy  out  1  high in any state other than IDLE.
frame_done  out  1  one-cycle pulse per frame handed to readout.
frame_cnt  out  32  frames handed off since the last start.
err  out  2  sticky: bit0 = watchdog timeout, bit1 = bad configuration.

Behaviour:
- Reset values: exp_re_busy = 1, all pulses = 0, busy = 0, frame_cnt = 0, err = 0, active shadow registers = 0, update_pending = 0.
- Reset mid-frame returns to IDLE immediately. The exposure engine sees re_busy = 1 and parks in HS_idle after its own reset.
- exp_re_busy is 1 in every state except LAUNCH.
- Shadow load:
  - cfg_update sets update_pending.
  - The copy into the active registers happens only in IDLE or ARM, on the cycle update_pending = 1, then clears the flag.
  - cfg_update arriving on that same cycle re-sets the flag; the newer data is loaded next.
- Bad configuration: active T1 == 0, Texp_ctrl == 0 or NUM_SUB == 0. cfg_start is then ignored and err[1] is set. err[1] clears only on a start with a good configuration.
- States:
  - IDLE: on cfg_start with cfg_mode != 0 and a good configuration, clear frame_cnt and go to ARM. cfg_start with mode 0 is ignored.
  - ARM: apply any pending shadow load. Go to LAUNCH when fifo_prog_full = 0 and (OVERLAP = 1 or ro_busy = 0). If stop_req is set, go to IDLE instead.
  - LAUNCH: exactly 1 cycle with exp_re_busy = 0, then EXPOSE.
  - EXPOSE: wait for exp_trigger = 1, then go to HANDOFF. exp_re_busy = 1 acknowledges the trigger, so the engine returns to idle.
  - HANDOFF: if ro_busy = 0, pulse ro_start and frame_done, increment frame_cnt, and go to RO_ACK. Otherwise hold (back-to-back frames with OVERLAP).
  - RO_ACK: wait for ro_busy = 1, then go to NEXT.
  - NEXT: go to IDLE if mode = 1, or mode = 2 and frame_cnt >= cfg_num_frames, or stop_req is set. Otherwise go to ARM.
- Stop handling: cfg_stop sets stop_req in any non-IDLE state. The frame in flight completes first; there is no abort of exposure. stop_req clears on entering IDLE.
- Mode 2 with cfg_num_frames = 0 behaves as single.
- frame_cnt saturates at 32'hFFFF_FFFF in continuous mode.
- Watchdog: a 32-bit counter cleared on every state change. When it reaches WDOG_CYCLES in EXPOSE or RO_ACK, set err[0] and go to IDLE.
- Simultaneous cfg_start and cfg_stop in IDLE: start wins, and stop_req is set, so exactly one frame runs.

Decomposition:
- Shared package exp_ro_pkg holds:
  - state encoding
  - mode constants
  - timing-word index constants: T_STDBY_IDX = 0 … T9_IDX = 12
  - err bit positions
- One natural sub-module, exp_cfg_shadow: the pending flag plus the active registers with a load strobe.

Test Plan:
- Single frame. Setup: mode 1, T1 = 4, NUM_SUB = 2; model the exposure engine trigger 500 cycles after launch. Expect exactly one 1-cycle exp_re_busy low, one ro_start, frame_cnt = 1, return to IDLE.
- N frames with back-pressure. Setup: mode 2, cfg_num_frames = 3, fifo_prog_full high for 100 cycles before frame 2. Expect no LAUNCH while full; frame_cnt = 3, three frame_done pulses, then IDLE.
- Shadow atomicity. Pulse cfg_update with T1 = 9 during EXPOSE of frame 1 (active T1 = 4). Expect cfg_timing_act to keep T1 = 4 until ARM of frame 2, then T1 = 9.
- Stop in continuous mode. Mode 3; pulse cfg_stop mid-EXPOSE of frame 5. Expect frame 5 to be handed off, frame_cnt = 5, no sixth launch, busy = 0.
- Watchdog. Setup: WDOG_CYCLES = 1000 in the bench; exp_trigger never asserted. Expect err[0] = 1 after 1000 cycles in EXPOSE, state IDLE, exp_re_busy = 1.
- Bad configuration and async reset. cfg_start with T1 = 0 gives err[1] = 1, busy = 0. Asserting rst_n low mid-RO_ACK forces all outputs to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/exp_ro_pkg.sv
// Shared definitions for the frame scheduler: FSM encoding, capture modes,
// timing-word positions inside the packed timing bus and error bit positions.
package exp_ro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_EXPOSE  = 3'd3,
        ST_HANDOFF = 3'd4,
        ST_RO_ACK  = 3'd5,
        ST_NEXT    = 3'd6
    } state_t;

    localparam logic [1:0] MODE_STOP    = 2'd0;
    localparam logic [1:0] MODE_SINGLE  = 2'd1;
    localparam logic [1:0] MODE_NFRAMES = 2'd2;
    localparam logic [1:0] MODE_CONT    = 2'd3;

    localparam int T_STDBY_IDX   = 0;
    localparam int T_RESET_IDX   = 1;
    localparam int TGL_RES_IDX   = 2;
    localparam int TEXP_CTRL_IDX = 3;
    localparam int T1_IDX        = 4;
    localparam int T2_IDX        = 5;
    localparam int T3_IDX        = 6;
    localparam int T4_IDX        = 7;
    localparam int T5_IDX        = 8;
    localparam int T6_IDX        = 9;
    localparam int T7_IDX        = 10;
    localparam int T8_IDX        = 11;
    localparam int T9_IDX        = 12;

    localparam int ERR_WDOG = 0;
    localparam int ERR_CFG  = 1;

endpackage

// File: rtl/exp_cfg_shadow.sv
// Shadow register bank: a pending flag plus the active timing/NUM_SUB set,
// copied as one unit when the scheduler opens the load window.
module exp_cfg_shadow #(
    parameter int NUM_T = 13
) (
    input  logic               CLKM,
    input  logic               rst_n,
    input  logic               update,
    input  logic               load_en,
    input  logic [31:0]        num_sub_in,
    input  logic [NUM_T*32-1:0] timing_in,
    output logic [31:0]        num_sub_act,
    output logic [NUM_T*32-1:0] timing_act,
    output logic               pending
);

    logic load;

    assign load = load_en && pending;

    // A request landing on the load cycle re-arms the flag so the newer set follows.
    always_ff @(posedge CLKM or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (update) begin
            pending <= 1'b1;
        end else if (load) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge CLKM or negedge rst_n) begin
        if (!rst_n) begin
            num_sub_act <= '0;
            timing_act  <= '0;
        end else if (load) begin
            num_sub_act <= num_sub_in;
            timing_act  <= timing_in;
        end
    end

endmodule

// File: rtl/exp_frame_scheduler.sv
// Frame-level sequencer: arms and launches exposures, hands frames to readout,
// and keeps the exposure timing set stable for the whole of every frame.
module exp_frame_scheduler
    import exp_ro_pkg::*;
#(
    parameter int          NUM_T       = 13,
    parameter bit          OVERLAP     = 1'b0,
    parameter logic [31:0] WDOG_CYCLES = 32'd200_000_000
) (
    input  logic                CLKM,
    input  logic                rst_n,
    input  logic [1:0]          cfg_mode,
    input  logic [31:0]         cfg_num_frames,
    input  logic                cfg_start,
    input  logic                cfg_stop,
    input  logic                cfg_update,
    input  logic [31:0]         cfg_num_sub_in,
    input  logic [NUM_T*32-1:0] cfg_timing_in,
    output logic [31:0]         cfg_num_sub_act,
    output logic [NUM_T*32-1:0] cfg_timing_act,
    output logic                exp_re_busy,
    input  logic                exp_trigger,
    output logic                ro_start,
    input  logic                ro_busy,
    input  logic                fifo_prog_full,
    output logic                busy,
    output logic                frame_done,
    output logic [31:0]         frame_cnt,
    output logic [1:0]          err
);

    state_t      state;
    state_t      state_next;
    logic [31:0] wdog_cnt;
    logic        stop_req;
    logic        one_shot;
    logic        update_pending;
    logic        cfg_good;
    logic        start_ok;
    logic        start_bad;
    logic        wdog_hit;
    logic        handoff;
    logic        run_done;
    logic        launch_ok;

    exp_cfg_shadow #(
        .NUM_T (NUM_T)
    ) u_shadow (
        .CLKM        (CLKM),
        .rst_n       (rst_n),
        .update      (cfg_update),
        .load_en     ((state == ST_IDLE) || (state == ST_ARM)),
        .num_sub_in  (cfg_num_sub_in),
        .timing_in   (cfg_timing_in),
        .num_sub_act (cfg_num_sub_act),
        .timing_act  (cfg_timing_act),
        .pending     (update_pending)
    );

    assign cfg_good  = (cfg_timing_act[T1_IDX*32 +: 32] != 32'd0)
                    && (cfg_timing_act[TEXP_CTRL_IDX*32 +: 32] != 32'd0)
                    && (cfg_num_sub_act != 32'd0);
    assign start_ok  = (state == ST_IDLE) && cfg_start && (cfg_mode != MODE_STOP) && cfg_good;
    assign start_bad = (state == ST_IDLE) && cfg_start && (cfg_mode != MODE_STOP) && !cfg_good;
    assign wdog_hit  = ((state == ST_EXPOSE) || (state == ST_RO_ACK)) && (wdog_cnt >= WDOG_CYCLES);
    assign handoff   = (state == ST_HANDOFF) && !ro_busy;
    assign launch_ok = !fifo_prog_full && (OVERLAP || !ro_busy);
    assign run_done  = (cfg_mode == MODE_STOP) || (cfg_mode == MODE_SINGLE)
                    || ((cfg_mode == MODE_NFRAMES) && (frame_cnt >= cfg_num_frames))
                    || stop_req;

    always_ff @(posedge CLKM or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start+stop pair sets one_shot so ARM does not abort the single frame it owes.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start_ok) state_next = ST_ARM;
            ST_ARM:     if (stop_req && !one_shot) state_next = ST_IDLE;
                        else if (launch_ok) state_next = ST_LAUNCH;
            ST_LAUNCH:  state_next = ST_EXPOSE;
            ST_EXPOSE:  if (wdog_hit) state_next = ST_IDLE;
                        else if (exp_trigger) state_next = ST_HANDOFF;
            ST_HANDOFF: if (!ro_busy) state_next = ST_RO_ACK;
            ST_RO_ACK:  if (wdog_hit) state_next = ST_IDLE;
                        else if (ro_busy) state_next = ST_NEXT;
            ST_NEXT:    state_next = run_done ? ST_IDLE : ST_ARM;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        exp_re_busy = (state != ST_LAUNCH);
        busy        = (state != ST_IDLE);
        ro_start    = handoff;
        frame_done  = handoff;
    end

    always_ff @(posedge CLKM or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt  <= '0;
            frame_cnt <= '0;
            stop_req  <= 1'b0;
            one_shot  <= 1'b0;
            err       <= '0;
        end else begin
            if (state_next != state) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt != 32'hFFFF_FFFF) begin
                wdog_cnt <= wdog_cnt + 32'd1;
            end

            if (start_ok) begin
                frame_cnt <= '0;
            end else if (handoff && (frame_cnt != 32'hFFFF_FFFF)) begin
                frame_cnt <= frame_cnt + 32'd1;
            end

            if (state == ST_IDLE) begin
                stop_req <= start_ok && cfg_stop;
                one_shot <= start_ok && cfg_stop;
            end else if (state_next == ST_IDLE) begin
                stop_req <= 1'b0;
                one_shot <= 1'b0;
            end else if (cfg_stop) begin
                stop_req <= 1'b1;
            end

            if (start_ok) begin
                err[ERR_CFG] <= 1'b0;
            end else if (start_bad) begin
                err[ERR_CFG] <= 1'b1;
            end

            if (wdog_hit) begin
                err[ERR_WDOG] <= 1'b1;
            end
        end
    end

endmodule
